piece_collide_check: RTL and testbench
======================================

# piece_collide_check

Sequential collision checker for the Tetris core. It consumes the four cell indices, width and height produced by the shape generator for a candidate piece placement. It reads the board occupancy RAM through a single synchronous read port and reports whether that placement overlaps settled blocks or leaves the playfield. The game controller uses it before committing any move, rotation or drop.

## Interface
Parameters:
- BLOCKS_WIDE, 14, playfield columns; cell index = row*BLOCKS_WIDE + col
- BLOCKS_HIGH, 18, playfield rows; BLOCKS_WIDE*BLOCKS_HIGH must be ≤ 255
- CELL_NONE, 8'hFF, cell index meaning "no cell" (empty shape)

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  asynchronous active-low reset
- Start  in  1  one-cycle request; sampled only while Busy=0
- Cur_1..Cur_4  in  8 each  candidate cell indices
- Pos_X  in  4  candidate column
- Pos_Y  in  5  candidate row
- Width  in  3  candidate width in cells (0 = empty shape)
- Height  in  3  candidate height in cells
- Rd_En  out  1  board RAM read enable
- Rd_Addr  out  8  board RAM address
- Rd_Data  in  1  occupancy bit, valid the cycle after Rd_En
- Busy  out  1  check in progress
- Done  out  1  one-cycle result strobe
- Collide  out  1  result; held until the next Done
- Hit_Mask  out  4  bit k-1 set if Cur_k read occupied; held with Collide

## Operation
- States: IDLE, BOUND, READ, DRAIN, DONE.
- IDLE: on Start, latch all inputs. Set Busy. Go to BOUND, or to READ when COLLIDE_BOUNDS_EN is absent.
- Empty shape (Width==0 or any Cur_k==CELL_NONE):
  - Skip all reads.
  - Next state is DONE with Collide=0 and Hit_Mask=0.
- BOUND:
  - Out of bounds if Pos_X+Width > BLOCKS_WIDE, or Pos_Y+Height > BLOCKS_HIGH, or any Cur_k ≥ BLOCKS_WIDE*BLOCKS_HIGH.
  - Compute the sums at 6-bit width; no wrap is allowed.
  - If out of bounds: go to DONE with Collide=1 and Hit_Mask=0. No reads are issued.
  - Otherwise go to READ.
- READ: issue Rd_Addr=Cur_1..Cur_4 on 4 consecutive cycles with Rd_En=1. The read is pipelined: each Rd_Data is sampled one cycle after its address.
- DRAIN: sample the last Rd_Data.
- DONE:
  - Pulse Done for one cycle.
  - Collide is the OR of Hit_Mask.
  - Clear Busy and return to IDLE.
- All four cells are always read; there is no early abort on the first hit.
- Start while Busy=1 is ignored; no queuing.
- Input changes after Start are ignored because the values are latched.

## Timing
- Reset values: Rd_En=0, Rd_Addr=0, Busy=0, Done=0, Collide=0, Hit_Mask=0, state IDLE.
- Reset asserted mid-check:
  - Abort immediately and return to IDLE.
  - No Done is produced.
- Start sampled at edge E0; Busy is high from E0.
- In-bounds check with COLLIDE_BOUNDS_EN defined:
  - Rd_En high in cycles E1–E5.
  - Rd_Data sampled at E2–E5.
  - Done high E5–E6; Busy falls at E6.
  - Latency is 5 cycles, Start-edge to Done-edge.
- In-bounds check without COLLIDE_BOUNDS_EN: the same sequence shifted one cycle earlier, so latency is 4.
- Out-of-bounds or empty shape: Done high E1–E2, or E2–E3 when passing through BOUND. Rd_En is never asserted.
- A new Start is accepted at the edge where Busy is sampled low (E6 at the earliest for a full check).
- Rd_Addr holds its last value when Rd_En=0.

## Configuration
- COLLIDE_BOUNDS_EN defined: the BOUND state exists and out-of-field placements report Collide=1 without RAM access.
- Undefined:
  - BOUND is removed and READ is entered directly.
  - The caller guarantees in-range indices.
  - Out-of-range indices are issued to the RAM unchecked.
  - Latency drops by one cycle.

## Structure
- Shared package tetris_pkg holds:
  - BLOCKS_WIDE, BLOCKS_HIGH, CELL_NONE
  - the 3-bit shape type encoding
  - the collide-check state enum
- One sub-module is natural: piece_bounds, a combinational in-field test on the latched Pos_X, Pos_Y, Width, Height and Cur_k. It is instantiated only under COLLIDE_BOUNDS_EN.
- The FSM, read sequencer and result registers stay in piece_collide_check.

## Test plan
- Vertical bar at Pos_X=3, Pos_Y=0 (Cur=3,17,31,45, W=1, H=4) on an empty board -> Rd_Addr 3,17,31,45 on 4 consecutive cycles; Done at E5; Collide=0; Hit_Mask=0000.
- Same bar with cell 31 set -> Collide=1, Hit_Mask=0100, all 4 reads still issued.
- Horizontal bar at Pos_X=11 (W=4) with COLLIDE_BOUNDS_EN -> no Rd_En; Done at E2; Collide=1. Without the macro -> 4 reads issued, latency 4.
- Empty shape (all Cur=8'hFF, W=0) -> Done at E1/E2, Collide=0, no reads.
- Start pulsed again during Busy -> ignored, exactly one Done. Rst_n pulled low at E3 -> all outputs 0 immediately, no Done, next Start behaves normally.
- Square at Pos_Y=16, H=2 (rows 16–17, last legal) -> in bounds, 4 reads. Pos_Y=17 -> Collide=1 with no reads.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared Tetris core definitions: playfield geometry, shape type encoding and
// the collision-checker state encoding.
package tetris_pkg;

    localparam int unsigned BLOCKS_WIDE = 14;
    localparam int unsigned BLOCKS_HIGH = 18;
    localparam logic [7:0]  CELL_NONE   = 8'hFF;

    typedef enum logic [2:0] {
        SHAPE_I = 3'd0,
        SHAPE_O = 3'd1,
        SHAPE_T = 3'd2,
        SHAPE_S = 3'd3,
        SHAPE_Z = 3'd4,
        SHAPE_J = 3'd5,
        SHAPE_L = 3'd6
    } shape_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BOUND = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } collide_state_t;

    // A shape with zero width or any unused cell slot never touches the board.
    function automatic logic shape_empty(input logic [2:0]      width,
                                         input logic [3:0][7:0] cells,
                                         input logic [7:0]      none);
        logic empty;
        empty = (width == 3'd0);
        for (int unsigned k = 0; k < 4; k++) begin
            if (cells[k] == none) empty = 1'b1;
        end
        return empty;
    endfunction

endpackage

// File: rtl/piece_bounds.sv
// Combinational in-field test for a latched piece placement; used by
// piece_collide_check only when COLLIDE_BOUNDS_EN is defined.
module piece_bounds #(
    parameter int unsigned BLOCKS_WIDE = tetris_pkg::BLOCKS_WIDE,
    parameter int unsigned BLOCKS_HIGH = tetris_pkg::BLOCKS_HIGH
) (
    input  logic [3:0]      pos_x,
    input  logic [4:0]      pos_y,
    input  logic [2:0]      width,
    input  logic [2:0]      height,
    input  logic [3:0][7:0] cells,
    output logic            in_field
);

    localparam logic [5:0] MAX_X     = 6'(BLOCKS_WIDE);
    localparam logic [5:0] MAX_Y     = 6'(BLOCKS_HIGH);
    localparam logic [8:0] NUM_CELLS = 9'(BLOCKS_WIDE * BLOCKS_HIGH);

    logic [5:0] right;
    logic [5:0] bottom;

    always_comb begin
        right    = {2'b00, pos_x} + {3'b000, width};
        bottom   = {1'b0, pos_y} + {3'b000, height};
        in_field = (right <= MAX_X) && (bottom <= MAX_Y);
        for (int unsigned k = 0; k < 4; k++) begin
            if ({1'b0, cells[k]} >= NUM_CELLS) in_field = 1'b0;
        end
    end

endmodule

// File: rtl/piece_collide_check.sv
// Sequential collision checker: reads the four candidate cells from the board
// RAM and reports overlap. COLLIDE_BOUNDS_EN adds an in-field pre-check state.
module piece_collide_check #(
    parameter int unsigned BLOCKS_WIDE = tetris_pkg::BLOCKS_WIDE,
    parameter int unsigned BLOCKS_HIGH = tetris_pkg::BLOCKS_HIGH,
    parameter logic [7:0]  CELL_NONE   = tetris_pkg::CELL_NONE
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic [7:0] Cur_1,
    input  logic [7:0] Cur_2,
    input  logic [7:0] Cur_3,
    input  logic [7:0] Cur_4,
    input  logic [3:0] Pos_X,
    input  logic [4:0] Pos_Y,
    input  logic [2:0] Width,
    input  logic [2:0] Height,
    output logic       Rd_En,
    output logic [7:0] Rd_Addr,
    input  logic       Rd_Data,
    output logic       Busy,
    output logic       Done,
    output logic       Collide,
    output logic [3:0] Hit_Mask
);
    import tetris_pkg::*;

    collide_state_t  state;
    logic [3:0][7:0] cells;
    logic [3:0][7:0] cur_in;
    logic [1:0]      idx;
    logic [2:0]      hits;
    logic            skip;
    logic            oob;

    assign cur_in = {Cur_4, Cur_3, Cur_2, Cur_1};

`ifdef COLLIDE_BOUNDS_EN
    logic [3:0] pos_x;
    logic [4:0] pos_y;
    logic [2:0] width;
    logic [2:0] height;
    logic       in_field;

    piece_bounds #(
        .BLOCKS_WIDE(BLOCKS_WIDE),
        .BLOCKS_HIGH(BLOCKS_HIGH)
    ) u_bounds (
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .width    (width),
        .height   (height),
        .cells    (cells),
        .in_field (in_field)
    );
`else
    logic unused_geom;
    assign unused_geom = ^{Pos_X, Pos_Y, Height};
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_IDLE;
            Rd_En    <= 1'b0;
            Rd_Addr  <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Collide  <= 1'b0;
            Hit_Mask <= '0;
            cells    <= '0;
            idx      <= '0;
            hits     <= '0;
            skip     <= 1'b0;
            oob      <= 1'b0;
`ifdef COLLIDE_BOUNDS_EN
            pos_x    <= '0;
            pos_y    <= '0;
            width    <= '0;
            height   <= '0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                // DONE also accepts Start so a new check can launch as Busy drops
                ST_IDLE, ST_DONE: begin
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                    if (Start) begin
                        Busy  <= 1'b1;
                        cells <= cur_in;
                        idx   <= 2'd1;
                        hits  <= '0;
                        skip  <= 1'b0;
                        oob   <= 1'b0;
`ifdef COLLIDE_BOUNDS_EN
                        pos_x  <= Pos_X;
                        pos_y  <= Pos_Y;
                        width  <= Width;
                        height <= Height;
                        state  <= ST_BOUND;
`else
                        if (shape_empty(Width, cur_in, CELL_NONE)) begin
                            skip  <= 1'b1;
                            state <= ST_DRAIN;
                        end else begin
                            Rd_En   <= 1'b1;
                            Rd_Addr <= Cur_1;
                            state   <= ST_READ;
                        end
`endif
                    end
                end
`ifdef COLLIDE_BOUNDS_EN
                ST_BOUND: begin
                    if (shape_empty(width, cells, CELL_NONE)) begin
                        skip  <= 1'b1;
                        state <= ST_DRAIN;
                    end else if (!in_field) begin
                        skip  <= 1'b1;
                        oob   <= 1'b1;
                        state <= ST_DRAIN;
                    end else begin
                        Rd_En   <= 1'b1;
                        Rd_Addr <= cells[0];
                        state   <= ST_READ;
                    end
                end
`endif
                // Data for the address issued last cycle arrives now; shift it in.
                ST_READ: begin
                    hits    <= {Rd_Data, hits[2:1]};
                    Rd_Addr <= cells[idx];
                    idx     <= idx + 2'd1;
                    if (idx == 2'd3) state <= ST_DRAIN;
                end
                // Skipped checks route through DRAIN so Done lands one cycle later.
                ST_DRAIN: begin
                    Rd_En <= 1'b0;
                    Done  <= 1'b1;
                    state <= ST_DONE;
                    if (skip) begin
                        Collide  <= oob;
                        Hit_Mask <= '0;
                    end else begin
                        Collide  <= Rd_Data | (|hits);
                        Hit_Mask <= {Rd_Data, hits};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_collide_check.sv
// Directed scoreboard bench for piece_collide_check; adapts expected latency and
// out-of-field behaviour to whether COLLIDE_BOUNDS_EN is defined.
module tb_piece_collide_check;

    localparam int unsigned BW = 14;
    localparam int unsigned BH = 18;
`ifdef COLLIDE_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif
    localparam int unsigned LAT_FULL  = BOUNDS ? 5 : 4;
    localparam int unsigned LAT_SHORT = BOUNDS ? 2 : 1;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Start;
    logic [7:0] Cur_1, Cur_2, Cur_3, Cur_4;
    logic [3:0] Pos_X;
    logic [4:0] Pos_Y;
    logic [2:0] Width, Height;
    logic       Rd_En;
    logic [7:0] Rd_Addr;
    logic       Rd_Data;
    logic       Busy, Done, Collide;
    logic [3:0] Hit_Mask;

    logic [255:0] board;

    typedef struct {
        logic            collide;
        logic [3:0]      mask;
        int unsigned     lat;
        int unsigned     nreads;
        logic [3:0][7:0] addr;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  rd_log[$];
    int unsigned done_count = 0;
    int          total = 0;
    int          bad = 0;

    piece_collide_check dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
        .Cur_1(Cur_1), .Cur_2(Cur_2), .Cur_3(Cur_3), .Cur_4(Cur_4),
        .Pos_X(Pos_X), .Pos_Y(Pos_Y), .Width(Width), .Height(Height),
        .Rd_En(Rd_En), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data),
        .Busy(Busy), .Done(Done), .Collide(Collide), .Hit_Mask(Hit_Mask)
    );

    // Board RAM: address register lives in the DUT, data follows it.
    assign Rd_Data = Rd_En & board[Rd_Addr];

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Rd_En) rd_log.push_back(Rd_Addr);
        if (Done) done_count++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0][7:0] c, input logic [3:0] px,
                                   input logic [4:0] py, input logic [2:0] w, input logic [2:0] h);
        exp_t e;
        bit   empty, oob;
        empty = (w == 3'd0);
        oob   = (int'(px) + int'(w) > int'(BW)) || (int'(py) + int'(h) > int'(BH));
        for (int k = 0; k < 4; k++) begin
            if (c[k] == 8'hFF) empty = 1'b1;
            if (int'(c[k]) >= int'(BW * BH)) oob = 1'b1;
        end
        e.collide = 1'b0;
        e.mask    = 4'b0000;
        e.lat     = LAT_SHORT;
        e.nreads  = 0;
        e.addr    = c;
        if (!empty) begin
            if (BOUNDS && oob) begin
                e.collide = 1'b1;
            end else begin
                e.lat    = LAT_FULL;
                e.nreads = 4;
                for (int k = 0; k < 4; k++) e.mask[k] = board[c[k]];
                e.collide = |e.mask;
            end
        end
        return e;
    endfunction

    task automatic run(input logic [3:0][7:0] c, input logic [3:0] px, input logic [4:0] py,
                       input logic [2:0] w, input logic [2:0] h, input bit repulse);
        exp_t        e;
        int unsigned lat, base_done;
        int          base_rd;
        @(negedge Clk);
        {Cur_4, Cur_3, Cur_2, Cur_1} = c;
        Pos_X = px; Pos_Y = py; Width = w; Height = h;
        Start = 1'b1;
        sb.push_back(model(c, px, py, w, h));
        base_rd   = rd_log.size();
        base_done = done_count;
        @(posedge Clk); #1;
        check("busy_after_start", Busy, 1);
        @(negedge Clk);
        Start = 1'b0;
        Cur_1 = 8'($urandom); Cur_2 = 8'($urandom); Cur_3 = 8'($urandom); Cur_4 = 8'($urandom);
        Pos_X = 4'($urandom); Pos_Y = 5'($urandom); Width = 3'($urandom); Height = 3'($urandom);
        for (lat = 1; lat <= 20; lat++) begin
            @(posedge Clk); #1;
            if (repulse) Start = (lat == 1);
            if (Done) break;
        end
        Start = 1'b0;
        e = sb.pop_front();
        check("done_latency", lat, e.lat);
        check("busy_at_done", Busy, 1);
        check("collide", Collide, e.collide);
        check("hit_mask", Hit_Mask, e.mask);
        check("read_count", rd_log.size() - base_rd, e.nreads);
        for (int k = 0; k < int'(e.nreads); k++) begin
            check($sformatf("rd_addr%0d", k),
                  (base_rd + k < rd_log.size()) ? 32'(rd_log[base_rd + k]) : 'x, e.addr[k]);
        end
        @(posedge Clk); #1;
        check("done_one_cycle", Done, 0);
        check("busy_cleared", Busy, 0);
        check("collide_held", Collide, e.collide);
        if (e.nreads != 0) check("rd_addr_hold", Rd_Addr, e.addr[3]);
        repeat (3) @(posedge Clk);
        #1;
        check("done_count", done_count - base_done, 1);
    endtask

    initial begin
        Start = 1'b0;
        Cur_1 = '0; Cur_2 = '0; Cur_3 = '0; Cur_4 = '0;
        Pos_X = '0; Pos_Y = '0; Width = '0; Height = '0;
        board = '0;
        #1 Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_rd_en", Rd_En, 0);
        check("rst_rd_addr", Rd_Addr, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_collide", Collide, 0);
        check("rst_hit_mask", Hit_Mask, 0);
        Rst_n = 1'b1;

        // Vertical bar, empty board, then with cell 31 occupied and a stray Start.
        run({8'd45, 8'd31, 8'd17, 8'd3}, 4'd3, 5'd0, 3'd1, 3'd4, 1'b0);
        board[31] = 1'b1;
        run({8'd45, 8'd31, 8'd17, 8'd3}, 4'd3, 5'd0, 3'd1, 3'd4, 1'b1);

        // Reset pulled mid-check at E3: outputs clear at once and no Done follows.
        begin
            int unsigned base_done;
            @(negedge Clk);
            {Cur_4, Cur_3, Cur_2, Cur_1} = {8'd45, 8'd31, 8'd17, 8'd3};
            Pos_X = 4'd3; Pos_Y = 5'd0; Width = 3'd1; Height = 3'd4;
            Start = 1'b1;
            base_done = done_count;
            @(posedge Clk); #1 Start = 1'b0;
            repeat (3) @(posedge Clk);
            #1 Rst_n = 1'b0;
            #1;
            check("abort_rd_en", Rd_En, 0);
            check("abort_rd_addr", Rd_Addr, 0);
            check("abort_busy", Busy, 0);
            check("abort_collide", Collide, 0);
            check("abort_hit_mask", Hit_Mask, 0);
            repeat (2) @(negedge Clk);
            Rst_n = 1'b1;
            repeat (8) @(posedge Clk);
            #1;
            check("abort_no_done", done_count - base_done, 0);
            check("abort_idle", Busy, 0);
        end
        run({8'd45, 8'd31, 8'd17, 8'd3}, 4'd3, 5'd0, 3'd1, 3'd4, 1'b0);

        // Horizontal bar hanging off the right edge.
        board[12] = 1'b1;
        run({8'd14, 8'd13, 8'd12, 8'd11}, 4'd11, 5'd0, 3'd4, 3'd1, 1'b0);

        // Empty shapes: all slots unused, and one unused slot with nonzero width.
        run({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4'd0, 5'd0, 3'd0, 3'd0, 1'b0);
        run({8'hFF, 8'd31, 8'd17, 8'd3}, 4'd3, 5'd0, 3'd1, 3'd3, 1'b0);

        // Square on the last legal rows, then one row lower.
        board[244] = 1'b1;
        board[1]   = 1'b1;
        run({8'd244, 8'd243, 8'd230, 8'd229}, 4'd5, 5'd16, 3'd2, 3'd2, 1'b0);
        run({8'd2, 8'd1, 8'd244, 8'd243}, 4'd5, 5'd17, 3'd2, 3'd2, 1'b0);

        // Cell index past the board with in-field geometry.
        run({8'd0, 8'd0, 8'd0, 8'd252}, 4'd0, 5'd0, 3'd1, 3'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
